// File: rtl/core_pkg.sv
// Shared types and constants for the core's hazard control logic.
// The optional perf counters in pipeline_hazard_ctrl are enabled with
// the HAZARD_PERF_CNT_EN macro.
package core_pkg;

  localparam int REG_ADDR_W  = 5;
  // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 4
  localparam int FLUSH_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_MULDIV = 2'd2
  } hzd_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  // A register that is being cleared must not also be held
  function automatic pipe_ctrl_t flush_wins(input pipe_ctrl_t c);
    pipe_ctrl_t r;
    r = c;
    if (c.if_id_flush) r.if_id_stall = 1'b0;
    if (c.id_ex_flush) r.id_ex_stall = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads
// the destination of a load currently in EX. x0 never creates a hazard.
module hazard_lu_detect
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  output logic                  lu_hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit     = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit     = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
  assign lu_hazard_o = ex_mem_read_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core. Arbitrates EX redirects,
// mul/div occupancy, load-use hazards and fetch wait states by fixed
// priority. Define HAZARD_PERF_CNT_EN to get saturating stall/flush
// cycle counters; otherwise those outputs are tied to zero.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_redirect_i,
  input  logic                  ex_muldiv_start_i,
  input  logic                  muldiv_done_i,
  input  logic                  imem_ready_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_stall_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hzd_state_e             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_left_q, flush_left_d;
  logic                   lu_hazard;
  pipe_ctrl_t             ctrl_raw;
  pipe_ctrl_t             ctrl;

  hazard_lu_detect u_lu_detect (
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .lu_hazard_o   (lu_hazard)
  );

  // State and remaining-flush-cycle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_left_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
    end
  end

  // Next-state selection by event priority
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    case (state_q)
      ST_RUN: begin
        if (ex_redirect_i) begin
          if (FLUSH_CYCLES > 1) begin
            state_d      = ST_FLUSH;
            flush_left_d = FLUSH_RELOAD;
          end
        end else if (ex_muldiv_start_i && !muldiv_done_i) begin
          state_d = ST_MULDIV;
        end
      end
      ST_FLUSH: begin
        if (ex_redirect_i) begin
          flush_left_d = FLUSH_RELOAD;
        end else if (flush_left_q <= 2'd1) begin
          flush_left_d = '0;
          state_d      = ST_RUN;
        end else begin
          flush_left_d = flush_left_q - 2'd1;
        end
      end
      ST_MULDIV: begin
        if (muldiv_done_i) state_d = ST_RUN;
      end
      default: begin
        state_d      = ST_RUN;
        flush_left_d = '0;
      end
    endcase
  end

  // Stall/flush outputs from current state and inputs, forced low in reset
  always_comb begin
    ctrl_raw = '0;
    case (state_q)
      ST_RUN: begin
        if (ex_redirect_i) begin
          ctrl_raw.if_id_flush = 1'b1;
          ctrl_raw.id_ex_flush = 1'b1;
        end else if (ex_muldiv_start_i) begin
          if (!muldiv_done_i) begin
            ctrl_raw.pc_stall     = 1'b1;
            ctrl_raw.if_id_stall  = 1'b1;
            ctrl_raw.id_ex_stall  = 1'b1;
            ctrl_raw.ex_mem_flush = 1'b1;
          end
        end else if (lu_hazard) begin
          ctrl_raw.pc_stall    = 1'b1;
          ctrl_raw.if_id_stall = 1'b1;
          ctrl_raw.id_ex_flush = 1'b1;
        end else if (!imem_ready_i) begin
          ctrl_raw.pc_stall    = 1'b1;
          ctrl_raw.if_id_flush = 1'b1;
        end
      end
      ST_FLUSH: begin
        ctrl_raw.if_id_flush = 1'b1;
        ctrl_raw.pc_stall    = !imem_ready_i;
        ctrl_raw.id_ex_flush = ex_redirect_i;
      end
      ST_MULDIV: begin
        if (!muldiv_done_i) begin
          ctrl_raw.pc_stall     = 1'b1;
          ctrl_raw.if_id_stall  = 1'b1;
          ctrl_raw.id_ex_stall  = 1'b1;
          ctrl_raw.ex_mem_flush = 1'b1;
        end
      end
      default: ctrl_raw = '0;
    endcase
    ctrl = rst_n ? flush_wins(ctrl_raw) : '0;
  end

  assign pc_stall_o     = ctrl.pc_stall;
  assign if_id_stall_o  = ctrl.if_id_stall;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_stall_o  = ctrl.id_ex_stall;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_flush_o = ctrl.ex_mem_flush;
  assign state_o        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counts of PC-stall and IF/ID-flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ctrl.pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ctrl.if_id_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3).
// With HAZARD_PERF_CNT_EN a second, 3-bit-counter instance checks saturation.
module tb_pipeline_hazard_ctrl;
  import core_pkg::*;

  // Expected control words: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] LU_S  = 6'b110010;
  localparam logic [5:0] RED   = 6'b001010;
  localparam logic [5:0] MD    = 6'b110101;
  localparam logic [5:0] IMEM  = 6'b101000;
  localparam logic [5:0] FL    = 6'b001000;
  localparam logic [5:0] FL_PC = 6'b101000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [REG_ADDR_W-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic                  id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic                  ex_redirect, ex_muldiv_start, muldiv_done, imem_ready;
  logic                  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush;
  logic [1:0]            state;
  logic [31:0]           stall_cnt, flush_cnt;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1_addr_i     (id_rs1_addr),
    .id_rs2_addr_i     (id_rs2_addr),
    .id_uses_rs1_i     (id_uses_rs1),
    .id_uses_rs2_i     (id_uses_rs2),
    .ex_mem_read_i     (ex_mem_read),
    .ex_rd_addr_i      (ex_rd_addr),
    .ex_redirect_i     (ex_redirect),
    .ex_muldiv_start_i (ex_muldiv_start),
    .muldiv_done_i     (muldiv_done),
    .imem_ready_i      (imem_ready),
    .pc_stall_o        (pc_stall),
    .if_id_stall_o     (if_id_stall),
    .if_id_flush_o     (if_id_flush),
    .id_ex_stall_o     (id_ex_stall),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_flush_o    (ex_mem_flush),
    .state_o           (state),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic       s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush, s_ex_mem_flush;
  logic [1:0] s_state;
  logic [2:0] s_stall_cnt, s_flush_cnt;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(3)) dut_sat (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1_addr_i     (id_rs1_addr),
    .id_rs2_addr_i     (id_rs2_addr),
    .id_uses_rs1_i     (id_uses_rs1),
    .id_uses_rs2_i     (id_uses_rs2),
    .ex_mem_read_i     (ex_mem_read),
    .ex_rd_addr_i      (ex_rd_addr),
    .ex_redirect_i     (ex_redirect),
    .ex_muldiv_start_i (ex_muldiv_start),
    .muldiv_done_i     (muldiv_done),
    .imem_ready_i      (imem_ready),
    .pc_stall_o        (s_pc_stall),
    .if_id_stall_o     (s_if_id_stall),
    .if_id_flush_o     (s_if_id_flush),
    .id_ex_stall_o     (s_id_ex_stall),
    .id_ex_flush_o     (s_id_ex_flush),
    .ex_mem_flush_o    (s_ex_mem_flush),
    .state_o           (s_state),
    .stall_cnt_o       (s_stall_cnt),
    .flush_cnt_o       (s_flush_cnt)
  );
`endif

  // Drive one cycle of inputs just after the falling edge, then settle.
  // lu_kind: 0 none, 1 load x5 / rs1=x5, 2 load x0 / rs1=rs2=x0,
  //          3 load x7 / rs2=x7 but rs2 unused, 4 load x7 / rs2=x7 used
  task automatic applyStimulus(input logic redirect, input logic start, input logic done,
                               input logic imem_rdy, input int lu_kind);
    @(negedge clk);
    ex_redirect     = redirect;
    ex_muldiv_start = start;
    muldiv_done     = done;
    imem_ready      = imem_rdy;
    ex_mem_read = 1'b0; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    case (lu_kind)
      1: begin ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
               id_rs2_addr = 5'd3; id_uses_rs2 = 1'b1; end
      2: begin ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; end
      3: begin ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd1; id_uses_rs1 = 1'b1;
               id_rs2_addr = 5'd7; id_uses_rs2 = 1'b0; end
      4: begin ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd1; id_uses_rs1 = 1'b1;
               id_rs2_addr = 5'd7; id_uses_rs2 = 1'b1; end
      default: ;
    endcase
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] exp_ctrl, input logic [1:0] exp_state);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, state};
    exp = {exp_ctrl, exp_state};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed ctrl/state=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    ex_redirect = 1'b0; ex_muldiv_start = 1'b0; muldiv_done = 1'b0; imem_ready = 1'b0;
    ex_mem_read = 1'b0; ex_rd_addr = '0; id_rs1_addr = '0; id_rs2_addr = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_outputs", NONE, 2'd0);
    rst_n = 1'b1;

    applyStimulus(0, 0, 0, 1, 0); checkOutput("idle", NONE, 2'd0);

    // mul/div occupancy: start + 5 busy cycles, then done
    applyStimulus(0, 1, 0, 1, 0); checkOutput("md_start", MD, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("md_busy1", MD, 2'd2);
    applyStimulus(0, 0, 0, 0, 1); checkOutput("md_ignore_lu_imem", MD, 2'd2);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("md_busy3", MD, 2'd2);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("md_busy4", MD, 2'd2);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("md_busy5", MD, 2'd2);
    applyStimulus(0, 0, 1, 1, 0); checkOutput("md_done", NONE, 2'd2);
`ifdef HAZARD_PERF_CNT_EN
    checkValue("perf_stall_md", stall_cnt, 32'd6);
    checkValue("perf_flush_md", flush_cnt, 32'd0);
`endif
    applyStimulus(0, 0, 0, 1, 0); checkOutput("md_back_run", NONE, 2'd0);

    // start and done together: no stall, no state change
    applyStimulus(0, 1, 1, 1, 0); checkOutput("md_start_done", NONE, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("md_start_done_after", NONE, 2'd0);

    // load-use variants
    applyStimulus(0, 0, 0, 1, 1); checkOutput("lu_rs1", LU_S, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("lu_rs1_after", NONE, 2'd0);
    applyStimulus(0, 0, 0, 1, 2); checkOutput("lu_rd_x0", NONE, 2'd0);
    applyStimulus(0, 0, 0, 1, 3); checkOutput("lu_rs2_unused", NONE, 2'd0);
    applyStimulus(0, 0, 0, 1, 4); checkOutput("lu_rs2", LU_S, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("lu_rs2_after", NONE, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    checkValue("perf_stall_8", stall_cnt, 32'd8);
    checkValue("perf_stall_sat", {29'd0, s_stall_cnt}, 32'd7);
`endif

    // redirect with three flush cycles
    applyStimulus(1, 0, 0, 1, 0); checkOutput("redir_c1", RED, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("redir_c2", FL, 2'd1);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("redir_c3", FL, 2'd1);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("redir_done", NONE, 2'd0);

    // redirect beats load-use; fetch wait during flush stalls the PC
    applyStimulus(1, 0, 0, 1, 1); checkOutput("redir_lu", RED, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("redir_lu_c2", FL, 2'd1);
    applyStimulus(0, 0, 0, 0, 0); checkOutput("flush_imem_wait", FL_PC, 2'd1);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("redir_lu_done", NONE, 2'd0);

    // fetch wait states in RUN
    applyStimulus(0, 0, 0, 0, 0); checkOutput("imem_wait1", IMEM, 2'd0);
    applyStimulus(0, 0, 0, 0, 0); checkOutput("imem_wait2", IMEM, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("imem_ready", NONE, 2'd0);

    // mul/div start beats load-use and fetch wait
    applyStimulus(0, 1, 0, 0, 1); checkOutput("md_over_lu", MD, 2'd0);
    applyStimulus(0, 0, 1, 1, 0); checkOutput("md_over_lu_done", NONE, 2'd2);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("md_over_lu_run", NONE, 2'd0);

    // redirect inside the flush window restarts the count
    applyStimulus(1, 0, 0, 1, 0); checkOutput("reload_c1", RED, 2'd0);
    applyStimulus(1, 0, 0, 1, 0); checkOutput("reload_in_flush", RED, 2'd1);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("reload_c3", FL, 2'd1);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("reload_c4", FL, 2'd1);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("reload_done", NONE, 2'd0);

    // redirect beats mul/div start
    applyStimulus(1, 1, 0, 1, 0); checkOutput("redir_over_md", RED, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("redir_over_md_c2", FL, 2'd1);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("redir_over_md_c3", FL, 2'd1);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("redir_over_md_done", NONE, 2'd0);

    // async reset in the middle of a mul/div
    applyStimulus(0, 1, 0, 1, 0); checkOutput("md2_start", MD, 2'd0);
    applyStimulus(0, 0, 0, 1, 0); checkOutput("md2_busy", MD, 2'd2);
    rst_n = 1'b0;
    imem_ready = 1'b0;
    #1 checkOutput("reset_mid_md", NONE, 2'd0);
    @(posedge clk);
    #1 checkOutput("reset_held", NONE, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    checkValue("perf_stall_reset", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 1, 0); checkOutput("after_reset", NONE, 2'd0);

`ifndef HAZARD_PERF_CNT_EN
    checkValue("perf_stall_tied", stall_cnt, 32'd0);
    checkValue("perf_flush_tied", flush_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives the stall/flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, EX-stage control redirects, multi-cycle mul/div occupancy and instruction-fetch wait states.
- Arbitrates these events by fixed priority through a small FSM.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- FLUSH_CYCLES, 1, cycles IF/ID flush is held after a redirect (legal 1..4).
- CNT_W, 32, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- id_rs1_addr_i  in  REG_ADDR_W  rs1 of instruction in ID.
- id_rs2_addr_i  in  REG_ADDR_W  rs2 of instruction in ID.
- id_uses_rs1_i  in  1  ID instruction reads rs1.
- id_uses_rs2_i  in  1  ID instruction reads rs2.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_rd_addr_i  in  REG_ADDR_W  rd of EX instruction.
- ex_redirect_i  in  1  taken branch/jump or mispredict resolved in EX.
- ex_muldiv_start_i  in  1  EX instruction launches a multi-cycle mul/div.
- muldiv_done_i  in  1  mul/div result valid this cycle.
- imem_ready_i  in  1  fetch data valid this cycle.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID.
- if_id_flush_o  out  1  clear IF/ID.
- id_ex_stall_o  out  1  hold ID/EX.
- id_ex_flush_o  out  1  clear ID/EX (bubble).
- ex_mem_flush_o  out  1  clear EX/MEM (bubble).
- state_o  out  2  current FSM state.
- stall_cnt_o  out  CNT_W  cycles with pc_stall_o=1 (feature only).
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1 (feature only).

Behaviour:
- Reset: async on rst_n low. State=ST_RUN, flush counter=0, perf counters=0. All stall/flush outputs read 0 while in reset.
- Outputs are combinational from registered state plus current inputs (zero latency). State and counters update on posedge clk.
- Load-use hazard (LU): ex_mem_read_i && ex_rd_addr_i!=0 && ((id_uses_rs1_i && rs1==rd) || (id_uses_rs2_i && rs2==rd)).
- States: ST_RUN=0, ST_FLUSH=1, ST_MULDIV=2; value 3 unused and recovers to ST_RUN.
- ST_RUN priority, highest first:
  1. ex_redirect_i: if_id_flush=1, id_ex_flush=1, PC not stalled (loads target). Go to ST_FLUSH if FLUSH_CYCLES>1, loading counter with FLUSH_CYCLES-1. LU and ex_muldiv_start_i are ignored.
  2. ex_muldiv_start_i: pc_stall, if_id_stall, id_ex_stall=1, ex_mem_flush=1. Go to ST_MULDIV. If muldiv_done_i is also high this cycle, stay in ST_RUN with no outputs asserted.
  3. LU: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle; stay in ST_RUN.
  4. !imem_ready_i: pc_stall=1, if_id_flush=1.
  5. Otherwise: all outputs 0.
- ST_FLUSH: if_id_flush=1, pc_stall=!imem_ready_i. Decrement counter; return to ST_RUN when it reaches 0. ex_redirect_i here reloads counter with FLUSH_CYCLES-1 and also asserts id_ex_flush.
- ST_MULDIV: pc_stall, if_id_stall, id_ex_stall=1, ex_mem_flush=1 every cycle. LU and imem are ignored. When muldiv_done_i=1: all outputs 0 that cycle and go to ST_RUN.
- A stall and a flush are never both asserted on the same register; flush wins.
- Reset asserted mid-operation (including ST_MULDIV) aborts immediately to ST_RUN.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt_o and flush_cnt_o increment by 1 on each cycle their respective output is high. They saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Decomposition:
- core_pkg holds: hzd_state_e enum (ST_RUN, ST_FLUSH, ST_MULDIV), REG_ADDR_W constant, and a pipe_ctrl_t struct bundling the six stall/flush bits for the top-level connections.
- Natural sub-module: hazard_lu_detect, a purely combinational load-use comparator. The FSM, flush counter and perf counters stay in the top.

Test Plan:
- Load x5 in EX, ID uses rs1=5 -> exactly 1 cycle of pc_stall=if_id_stall=id_ex_flush=1; same with rd=0 -> no stall.
- ex_redirect_i pulse with FLUSH_CYCLES=3 -> if_id_flush=1 for 3 consecutive cycles, id_ex_flush only on cycle 1, state_o 0->1->1->0.
- ex_muldiv_start_i then muldiv_done_i 6 cycles later -> stall/ex_mem_flush high for 6 cycles, all 0 on the done cycle, state_o=2 then 0.
- Redirect and LU in the same cycle -> flushes only, pc_stall=0; imem_ready_i=0 for 2 cycles in RUN -> pc_stall=if_id_flush=1 for 2 cycles.
- rst_n low mid-ST_MULDIV -> state_o=0 and outputs 0 without waiting for a clock edge.
- With HAZARD_PERF_CNT_EN, scenario 3 -> stall_cnt_o=6. Preloaded near max -> counter holds at all-ones.
